// File: rtl/reset_ctrl_pkg.sv
// rtl/reset_ctrl_pkg.sv - shared types and helpers for the reset controller
//
// Purpose : FSM state encoding, reset-cause codes and a small elaboration helper.
// Ports   : none (package).

package reset_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_SOFT = 2'b01,
        CAUSE_WDT  = 2'b10
    } cause_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_ctrl_if.sv
// rtl/reset_ctrl_if.sv - request/status bundle between reset controller and its user
//
// Purpose : groups software request, watchdog controls and the reset outputs.
// Ports   : i_soft_rst_req, i_wdt_en, i_wdt_kick, i_wdt_limit (toward controller),
//           o_rst, o_ready, o_rst_cause (from controller).
//           master = requester side, slave = reset controller side.

interface reset_ctrl_if
    import reset_ctrl_pkg::*;
#(
    parameter int N_DOMAINS = 3,
    parameter int WDT_W     = 16
);
    logic                 i_soft_rst_req;
    logic                 i_wdt_en;
    logic                 i_wdt_kick;
    logic [WDT_W-1:0]     i_wdt_limit;
    logic [N_DOMAINS-1:0] o_rst;
    logic                 o_ready;
    cause_e               o_rst_cause;

    modport master (
        output i_soft_rst_req, i_wdt_en, i_wdt_kick, i_wdt_limit,
        input  o_rst, o_ready, o_rst_cause
    );

    modport slave (
        input  i_soft_rst_req, i_wdt_en, i_wdt_kick, i_wdt_limit,
        output o_rst, o_ready, o_rst_cause
    );
endinterface

// File: rtl/reset_ctrl_wdt.sv
// rtl/reset_ctrl_wdt.sv - watchdog counter with kick, enable and programmable limit
//
// Purpose : counts cycles while armed; raises a one-cycle fire pulse on timeout.
// Ports   : i_clk, i_rst_n   clock, async active-low reset
//           i_run            controller is in RUN (only then may the count advance)
//           i_clr            a reset request is being taken this edge
//           i_en, i_kick     enable, service pulse
//           i_limit          timeout in cycles, 0 disables firing
//           o_fire           timeout pulse (combinational from registered count)

module reset_ctrl_wdt
    import reset_ctrl_pkg::*;
#(
    parameter int WDT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_kick,
    input  logic [WDT_W-1:0] i_limit,
    output logic             o_fire
);

    logic [WDT_W-1:0] count_q;
    logic [WDT_W-1:0] count_d;
    logic             active;

    assign active = i_run && i_en && (i_limit != '0);

    // Count reaches limit-1 on the (limit-1)th edge after a clear, so firing
    // here makes the reset land exactly limit cycles after the last clear.
    assign o_fire = active && !i_kick && (count_q == (i_limit - WDT_W'(1)));

    always_comb begin
        count_d = count_q;
        if (i_clr || !active || i_kick) begin
            count_d = '0;
        end else if (count_q != '1) begin
            count_d = count_q + WDT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reset_ctrl.sv
// rtl/reset_ctrl.sv - stretched, staged per-domain reset generator
//
// Purpose : holds all domain resets for a stretch period after the last request,
//           then releases them one by one (domain 0 first), records the cause and
//           flags when every domain runs.
// Ports   : i_clk, i_rst_n   clock, async active-low power-on reset
//           bus (slave)      soft request, watchdog controls, o_rst/o_ready/o_rst_cause

module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int N_DOMAINS      = 3,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 8,
    parameter int WDT_W          = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    reset_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(max2(STRETCH_CYCLES, STAGE_GAP) + 1);
    localparam int STG_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [STG_W-1:0]     stage_q;
    logic [N_DOMAINS-1:0] rst_q;
    logic                 ready_q;
    cause_e               cause_q;

    logic wdt_fire;
    logic req;

    assign req = bus.i_soft_rst_req || wdt_fire;

    reset_ctrl_wdt #(
        .WDT_W (WDT_W)
    ) u_wdt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_run   (state_q == ST_RUN),
        .i_clr   (req),
        .i_en    (bus.i_wdt_en),
        .i_kick  (bus.i_wdt_kick),
        .i_limit (bus.i_wdt_limit),
        .o_fire  (wdt_fire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            cause_q <= CAUSE_POR;
        end else if (req) begin
            // Any request restarts the stretch; a held request keeps restarting it.
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
            cause_q <= wdt_fire ? CAUSE_WDT : CAUSE_SOFT;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
                        rst_q[0] <= 1'b0;
                        cnt_q    <= '0;
                        if (N_DOMAINS == 1) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                            stage_q <= STG_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
                        rst_q[stage_q] <= 1'b0;
                        cnt_q          <= '0;
                        stage_q        <= stage_q + STG_W'(1);
                        if (stage_q == STG_W'(N_DOMAINS - 1)) begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    rst_q   <= '0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_ASSERT;
                    cnt_q   <= '0;
                    stage_q <= '0;
                    rst_q   <= '1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_rst       = rst_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_rst_cause = cause_q;

endmodule
